// File: rtl/window_generator_pkg.sv
// rtl/window_generator_pkg.sv - frame geometry, window types and position helper for the window generator
package window_generator_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int KERNEL_SIZE   = 3;
  localparam int IMAGE_WIDTH   = 5;
  localparam int IMAGE_HEIGHT  = 5;
  localparam int WINDOW_COUNT  = (IMAGE_HEIGHT - KERNEL_SIZE + 1) * (IMAGE_WIDTH - KERNEL_SIZE + 1);
  localparam int ROW_CNT_WIDTH = $clog2(IMAGE_HEIGHT);
  localparam int COL_CNT_WIDTH = $clog2(IMAGE_WIDTH);

  typedef logic [DATA_WIDTH-1:0] pixel_t;
  typedef logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] window_t;
  typedef logic [ROW_CNT_WIDTH-1:0] row_cnt_t;
  typedef logic [COL_CNT_WIDTH-1:0] col_cnt_t;

  // A pixel closes a full window once enough rows and columns precede it.
  function automatic logic window_pos(input int row, input int col);
    return (row >= KERNEL_SIZE - 1) && (col >= KERNEL_SIZE - 1);
  endfunction

endpackage

// File: rtl/window_generator_if.sv
// rtl/window_generator_if.sv - pixel input stream and window output stream of the window generator
interface window_generator_if;
  import window_generator_pkg::*;

  pixel_t  pixel_in;
  logic    pixel_valid;
  logic    pixel_ready;
  window_t window_out;
  logic    window_valid;
  logic    window_ready;
  logic    window_last;

  modport master (
    output pixel_in, pixel_valid, window_ready,
    input  pixel_ready, window_out, window_valid, window_last
  );

  modport slave (
    input  pixel_in, pixel_valid, window_ready,
    output pixel_ready, window_out, window_valid, window_last
  );

endinterface

// File: rtl/window_generator_line_buffer.sv
// rtl/window_generator_line_buffer.sv - one-row pixel delay, shifts only on accepted pixels
module window_generator_line_buffer import window_generator_pkg::*; (
  input  logic   clk,
  input  logic   enable,
  input  pixel_t data_in,
  output pixel_t data_out
);

  pixel_t storage [IMAGE_WIDTH];

  // Storage is deliberately unreset: its contents only reach the window after a full row was written.
  always_ff @(posedge clk) begin
    if (enable) begin
      storage[0] <= data_in;
      for (int i = 1; i < IMAGE_WIDTH; i++) begin
        storage[i] <= storage[i-1];
      end
    end
  end

  assign data_out = storage[IMAGE_WIDTH-1];

endmodule

// File: rtl/window_generator.sv
// rtl/window_generator.sv - raster pixel stream to KxK stride-1 feature windows with ready/valid handshake
module window_generator import window_generator_pkg::*; (
  input logic               clk,
  input logic               reset,
  window_generator_if.slave bus
);

  localparam int K = KERNEL_SIZE;

  row_cnt_t row;
  col_cnt_t col;
  logic     pixel_ready;
  logic     accept;
  logic     col_end;
  logic     frame_end;
  logic     emit;
  window_t  shift_win;
  window_t  next_win;
  window_t  out_win;
  logic     out_valid;
  logic     out_last;

  // chain[d] is the pixel d rows above the incoming one, same column.
  pixel_t chain [K];

  assign pixel_ready = !out_valid || bus.window_ready;
  assign accept      = bus.pixel_valid && pixel_ready;
  assign col_end     = (col == col_cnt_t'(IMAGE_WIDTH - 1));
  assign frame_end   = col_end && (row == row_cnt_t'(IMAGE_HEIGHT - 1));
  assign emit        = window_pos(int'(row), int'(col));
  assign chain[0]    = bus.pixel_in;

  for (genvar g = 0; g < K - 1; g++) begin : g_line
    window_generator_line_buffer u_line (
      .clk      (clk),
      .enable   (accept),
      .data_in  (chain[g]),
      .data_out (chain[g+1])
    );
  end

  // Window slides one column left; the new right column comes from the line-buffer taps.
  always_comb begin
    next_win = shift_win;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++) begin
        next_win[i][j] = shift_win[i][j+1];
      end
      next_win[i][K-1] = chain[K-1-i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= frame_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_win <= '0;
    end else if (accept) begin
      shift_win <= next_win;
    end
  end

  // Output register only reloads on completing pixels, so it stays stable while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_win   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= emit;
      out_last  <= emit && frame_end;
      if (emit) begin
        out_win <= next_win;
      end
    end else if (bus.window_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign bus.pixel_ready  = pixel_ready;
  assign bus.window_out   = out_win;
  assign bus.window_valid = out_valid;
  assign bus.window_last  = out_last;

endmodule
